// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues in-order word fetches,
// tracks the address of every outstanding request, buffers returned words
// and presents {instr, pc} pairs to decode. A redirect flushes the buffer
// and marks every still-outstanding response to be discarded on return.

module fetch_ctrl_chk #(
  parameter int CW    = 3,
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  input logic          rvalid,
  input logic [CW-1:0] inflight,
  input logic [CW:0]   occupancy
);
  // Read data with no outstanding request is tolerated by the datapath, but flagged.
  a_orphan_rvalid : assert property (@(posedge clk) disable iff (rst)
    !(rvalid && (inflight == {CW{1'b0}})))
    else $warning("fetch_ctrl: rvalid with no request outstanding, word ignored");

  // Outstanding requests plus buffered words never exceed the buffer size.
  a_occupancy : assert property (@(posedge clk) disable iff (rst)
    occupancy <= (CW+1)'(DEPTH));
endmodule

module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  input  logic        i_instr_ready
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW:0]   DEPTH_V  = (CW+1)'(DEPTH);

  logic [31:0]   pc;
  logic [31:0]   tag_mem [DEPTH];
  logic [PW-1:0] tag_rd;
  logic [PW-1:0] tag_wr;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop;
  logic [31:0]   iq_instr [DEPTH];
  logic [31:0]   iq_pc [DEPTH];
  logic [PW-1:0] iq_rd;
  logic [PW-1:0] iq_wr;
  logic [CW-1:0] iq_count;

  logic [CW:0]   occupancy;
  logic          issue;
  logic          resp;
  logic          resp_keep;
  logic          resp_drop;
  logic          pop;
  logic [31:0]   pc_nxt;
  logic [CW-1:0] inflight_nxt;
  logic [CW-1:0] drop_nxt;
  logic [CW-1:0] iq_count_nxt;

  // Handshake qualifiers and the externally visible outputs.
  always_comb begin
    occupancy     = {1'b0, inflight} + {1'b0, iq_count};
    o_imem_req    = ~i_reset & ~i_redirect & (occupancy < DEPTH_V);
    o_imem_addr   = pc;
    issue         = o_imem_req & i_imem_gnt;
    // A response with nothing outstanding is ignored entirely.
    resp          = i_imem_rvalid & (inflight != CNT_ZERO);
    // Words returned during a redirect, or owed to an earlier redirect, are discarded.
    resp_keep     = resp & ~i_redirect & (drop == CNT_ZERO);
    resp_drop     = resp & ~i_redirect & (drop != CNT_ZERO);
    o_instr_valid = (iq_count != CNT_ZERO) & ~i_redirect;
    o_instr       = iq_instr[iq_rd];
    o_pc          = iq_pc[iq_rd];
    pop           = o_instr_valid & i_instr_ready;
  end

  // Next values of the PC and the occupancy/drop counters.
  always_comb begin
    pc_nxt       = pc;
    drop_nxt     = drop;
    iq_count_nxt = iq_count;
    inflight_nxt = inflight + (issue ? CNT_ONE : CNT_ZERO) - (resp ? CNT_ONE : CNT_ZERO);
    if (i_redirect) begin
      // No issue happens this cycle, so everything still outstanding is stale.
      pc_nxt       = i_redirect_pc & 32'hFFFF_FFFC;
      drop_nxt     = inflight - (resp ? CNT_ONE : CNT_ZERO);
      iq_count_nxt = CNT_ZERO;
    end else begin
      if (issue) begin
        pc_nxt = pc + 32'd4;
      end else begin
        pc_nxt = pc;
      end
      drop_nxt     = drop - (resp_drop ? CNT_ONE : CNT_ZERO);
      iq_count_nxt = iq_count + (resp_keep ? CNT_ONE : CNT_ZERO) - (pop ? CNT_ONE : CNT_ZERO);
    end
  end

  // PC and counter registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc       <= RESET_PC;
      inflight <= CNT_ZERO;
      drop     <= CNT_ZERO;
      iq_count <= CNT_ZERO;
    end else begin
      pc       <= pc_nxt;
      inflight <= inflight_nxt;
      drop     <= drop_nxt;
      iq_count <= iq_count_nxt;
    end
  end

  // Address-tag FIFO: one entry per outstanding request, popped by every response.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tag_rd <= {PW{1'b0}};
      tag_wr <= {PW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        tag_mem[i] <= 32'h0000_0000;
      end
    end else begin
      if (issue) begin
        tag_mem[tag_wr] <= pc;
        tag_wr          <= tag_wr + PTR_ONE;
      end
      if (resp) begin
        tag_rd <= tag_rd + PTR_ONE;
      end
    end
  end

  // Instruction FIFO; its head drives o_instr/o_pc directly from flops.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      iq_rd <= {PW{1'b0}};
      iq_wr <= {PW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        iq_instr[i] <= 32'h0000_0000;
        iq_pc[i]    <= RESET_PC;
      end
    end else if (i_redirect) begin
      iq_rd <= iq_wr;
    end else begin
      if (resp_keep) begin
        iq_instr[iq_wr] <= i_imem_rdata;
        iq_pc[iq_wr]    <= tag_mem[tag_rd];
        iq_wr           <= iq_wr + PTR_ONE;
      end
      if (pop) begin
        iq_rd <= iq_rd + PTR_ONE;
      end
    end
  end

  fetch_ctrl_chk #(.CW(CW), .DEPTH(DEPTH)) u_chk (
    .clk       (i_clk),
    .rst       (i_reset),
    .rvalid    (i_imem_rvalid),
    .inflight  (inflight),
    .occupancy (occupancy)
  );
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl with a queue-based instruction memory
// (1-cycle latency, responses can be held back) and a delivery scoreboard.
module tb_fetch_ctrl;
  logic        clk;
  logic        i_reset;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        i_instr_ready;

  int n_tests = 0;
  int n_fail  = 0;

  logic        mem_hold;
  logic [31:0] mq [$];
  logic [31:0] dpc [$];
  logic [31:0] dins [$];
  logic        obs_req;
  logic [31:0] obs_addr;
  logic        obs_valid;
  logic [31:0] obs_pc;
  logic [31:0] obs_instr;

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_instr_valid (o_instr_valid),
    .o_instr       (o_instr),
    .o_pc          (o_pc),
    .i_instr_ready (i_instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] dpc_at(input int k);
    return (k < dpc.size()) ? dpc[k] : 32'hXXXX_XXXX;
  endfunction

  // One clock cycle: observe at the falling edge, then update the memory model.
  task automatic tick();
    logic        iss;
    logic [31:0] iss_addr;
    @(negedge clk);
    obs_req   = o_imem_req;
    obs_addr  = o_imem_addr;
    obs_valid = o_instr_valid;
    obs_pc    = o_pc;
    obs_instr = o_instr;
    iss       = o_imem_req & i_imem_gnt;
    iss_addr  = o_imem_addr;
    if (o_instr_valid && i_instr_ready) begin
      dpc.push_back(o_pc);
      dins.push_back(o_instr);
    end
    @(posedge clk);
    #1;
    if (iss) mq.push_back(iss_addr);
    if (!mem_hold && mq.size() > 0) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = word(mq.pop_front());
    end else begin
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = 32'h0000_0000;
    end
  endtask

  task automatic apply_reset();
    i_reset       = 1'b1;
    i_redirect    = 1'b0;
    mq.delete();
    i_imem_rvalid = 1'b0;
    tick();
    tick();
    i_reset = 1'b0;
    dpc.delete();
    dins.delete();
  endtask

  task automatic test_reset();
    tick();
    n_tests++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", obs_req); end
    n_tests++; if (obs_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", obs_addr); end
    n_tests++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", obs_valid); end
    n_tests++; if (obs_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", obs_instr); end
    n_tests++; if (obs_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", obs_pc); end
    i_imem_gnt = 1'b1; i_instr_ready = 1'b1; mem_hold = 1'b0;
    i_reset = 1'b0;
  endtask

  task automatic test_stream();
    tick(); // cycle 0
    n_tests++; if ({obs_req, obs_addr} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL stream_c0_req: got %b/%h expected 1/0", obs_req, obs_addr); end
    n_tests++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL stream_c0_valid: got %b expected 0", obs_valid); end
    tick(); // cycle 1
    n_tests++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL stream_c1_nobypass: got %b expected 0", obs_valid); end
    n_tests++; if (obs_addr !== 32'h4) begin n_fail++; $display("FAIL stream_c1_addr: got %h expected 4", obs_addr); end
    for (int k = 0; k < 4; k++) begin
      tick(); // cycles 2..5
      n_tests++; if ({obs_valid, obs_pc} !== {1'b1, 32'(k * 4)}) begin n_fail++; $display("FAIL stream_pc: got %b/%h expected 1/%h", obs_valid, obs_pc, k * 4); end
      n_tests++; if (obs_instr !== word(32'(k * 4))) begin n_fail++; $display("FAIL stream_instr: got %h expected %h", obs_instr, word(32'(k * 4))); end
    end
  endtask

  task automatic test_backpressure();
    i_imem_gnt = 1'b1; i_instr_ready = 1'b0; mem_hold = 1'b0;
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c >= 4) begin
        n_tests++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_drop c%0d: got %b expected 0", c, obs_req); end
      end
      if (c >= 2) begin
        n_tests++; if ({obs_valid, obs_pc} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL bp_hold c%0d: got %b/%h expected 1/0", c, obs_valid, obs_pc); end
      end
    end
    i_instr_ready = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    n_tests++; if (dpc.size() < 6) begin n_fail++; $display("FAIL bp_count: got %0d expected >=6", dpc.size()); end
    for (int k = 0; k < 6; k++) begin
      n_tests++; if (dpc_at(k) !== 32'(k * 4)) begin n_fail++; $display("FAIL bp_order[%0d]: got %h expected %h", k, dpc_at(k), k * 4); end
    end
  endtask

  task automatic test_redirect_drop();
    i_imem_gnt = 1'b1; i_instr_ready = 1'b1; mem_hold = 1'b1;
    apply_reset();
    tick(); tick(); // issue 0 and 4, responses held
    i_imem_gnt = 1'b0; i_redirect = 1'b1; i_redirect_pc = 32'h0000_0100;
    tick();
    n_tests++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL rd_req_blocked: got %b expected 0", obs_req); end
    i_redirect = 1'b0; i_imem_gnt = 1'b1; mem_hold = 1'b0;
    dpc.delete(); dins.delete();
    tick();
    n_tests++; if (obs_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL rd_addr: got %h expected 100", obs_addr); end
    for (int c = 0; c < 8; c++) tick();
    n_tests++; if (dpc_at(0) !== 32'h0000_0100) begin n_fail++; $display("FAIL rd_first_pc: got %h expected 100", dpc_at(0)); end
    n_tests++; if (dpc_at(1) !== 32'h0000_0104) begin n_fail++; $display("FAIL rd_second_pc: got %h expected 104", dpc_at(1)); end
    n_tests++; if (dins.size() == 0 || dins[0] !== word(32'h0000_0100)) begin n_fail++; $display("FAIL rd_first_instr: expected %h, %0d delivered", word(32'h100), dins.size()); end
  endtask

  task automatic test_redirect_align();
    i_redirect = 1'b1; i_redirect_pc = 32'h0000_0203;
    tick();
    n_tests++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL al_valid_masked: got %b expected 0", obs_valid); end
    i_redirect = 1'b0;
    dpc.delete(); dins.delete();
    tick();
    n_tests++; if (obs_addr !== 32'h0000_0200) begin n_fail++; $display("FAIL al_addr: got %h expected 200", obs_addr); end
    for (int c = 0; c < 5; c++) tick();
    n_tests++; if (dpc_at(0) !== 32'h0000_0200) begin n_fail++; $display("FAIL al_first_pc: got %h expected 200", dpc_at(0)); end
    n_tests++; if (dpc_at(1) !== 32'h0000_0204) begin n_fail++; $display("FAIL al_second_pc: got %h expected 204", dpc_at(1)); end
  endtask

  task automatic test_stall_redirect();
    i_imem_gnt = 1'b1; i_instr_ready = 1'b1; mem_hold = 1'b0;
    apply_reset();
    tick(); tick(); // issue 0 and 4
    i_imem_gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++; if ({obs_req, obs_addr} !== {1'b1, 32'h8}) begin n_fail++; $display("FAIL stall_addr c%0d: got %b/%h expected 1/8", c, obs_req, obs_addr); end
    end
    i_redirect = 1'b1; i_redirect_pc = 32'h0000_0040;
    tick();
    i_redirect = 1'b0;
    tick();
    n_tests++; if (obs_addr !== 32'h0000_0040) begin n_fail++; $display("FAIL stall_redirect_addr: got %h expected 40", obs_addr); end
    i_imem_gnt = 1'b1;
    dpc.delete(); dins.delete();
    for (int c = 0; c < 5; c++) tick();
    n_tests++; if (dpc_at(0) !== 32'h0000_0040) begin n_fail++; $display("FAIL stall_first_pc: got %h expected 40", dpc_at(0)); end
  endtask

  task automatic test_reset_midflight();
    i_imem_gnt = 1'b1; i_instr_ready = 1'b0; mem_hold = 1'b0;
    apply_reset();
    tick(); // issue 0, its response is released next cycle
    mem_hold = 1'b1;
    tick(); tick(); tick(); // issue 4, 8, C while 0 is buffered
    tick();
    n_tests++; if ({obs_req, obs_valid} !== 2'b01) begin n_fail++; $display("FAIL mf_full: got req/valid %b/%b expected 0/1", obs_req, obs_valid); end
    i_reset = 1'b1;
    #1;
    n_tests++; if ({o_imem_req, o_instr_valid} !== 2'b00) begin n_fail++; $display("FAIL mf_reset_flags: got %b%b expected 00", o_imem_req, o_instr_valid); end
    n_tests++; if ({o_imem_addr, o_pc, o_instr} !== 96'h0) begin n_fail++; $display("FAIL mf_reset_data: got %h/%h/%h expected 0/0/0", o_imem_addr, o_pc, o_instr); end
    mq.delete(); mem_hold = 1'b0; i_imem_rvalid = 1'b0;
    tick();
    i_imem_rvalid = 1'b1; i_imem_rdata = 32'hBAD0_BAD0; // orphan response from before the reset
    i_reset = 1'b0; i_instr_ready = 1'b1;
    dpc.delete(); dins.delete();
    for (int c = 0; c < 6; c++) tick();
    n_tests++; if (dpc_at(0) !== 32'h0) begin n_fail++; $display("FAIL mf_restart_pc: got %h expected 0", dpc_at(0)); end
    n_tests++; if (dins.size() == 0 || dins[0] !== word(32'h0)) begin n_fail++; $display("FAIL mf_late_rvalid: expected %h, %0d delivered", word(32'h0), dins.size()); end
    n_tests++; if (dpc_at(1) !== 32'h4) begin n_fail++; $display("FAIL mf_second_pc: got %h expected 4", dpc_at(1)); end
  endtask

  task automatic test_wrap();
    i_imem_gnt = 1'b1; i_instr_ready = 1'b1; mem_hold = 1'b0;
    i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFC;
    tick();
    i_redirect = 1'b0;
    dpc.delete(); dins.delete();
    tick();
    n_tests++; if ({obs_req, obs_addr} !== {1'b1, 32'hFFFF_FFFC}) begin n_fail++; $display("FAIL wrap_top: got %b/%h expected 1/fffffffc", obs_req, obs_addr); end
    tick();
    n_tests++; if (obs_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_zero: got %h expected 0", obs_addr); end
    for (int c = 0; c < 4; c++) tick();
    n_tests++; if (dpc_at(0) !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc0: got %h expected fffffffc", dpc_at(0)); end
    n_tests++; if (dpc_at(1) !== 32'h0) begin n_fail++; $display("FAIL wrap_pc1: got %h expected 0", dpc_at(1)); end
  endtask

  initial begin
    i_reset       = 1'b1;
    i_imem_gnt    = 1'b0;
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = 32'h0;
    i_redirect    = 1'b0;
    i_redirect_pc = 32'h0;
    i_instr_ready = 1'b0;
    mem_hold      = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_redirect_align();
    test_stall_redirect();
    test_reset_midflight();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
